toa_raw_generator: RTL and testbench

Synthesisable TOA raw-code emulator: converts a target time code (3-bit coarse, 7-bit fine) into the 63-bit delay-line raw word plus counterA/counterB values that the TOA encoder decodes. It sits in front of the encoder on the FPGA test path. It replaces file-driven stimulus with single-code injection or an on-chip linear sweep, and supports optional bubble insertion to exercise the encoder error flag.

---
 rtl/toa_raw_generator.sv | 260 ++++++++++++++++++++++++++
 tb/tb_toa_raw_generator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/toa_raw_generator.sv
// TOA raw-code emulator: turns a coarse/fine time code into the delay-line word and counterA/B values.
// Optional sweep engine is compiled in with `define TOA_RAW_GEN_SWEEP_EN.
module toa_raw_generator #(
    parameter int SWEEP_LEN_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_coarse,
    input  logic [6:0]                 in_fine,
    input  logic                       sweep_start,
    input  logic [6:0]                 sweep_step,
    input  logic [SWEEP_LEN_WIDTH-1:0] sweep_len,
    output logic                       sweep_busy,
    output logic                       sweep_done,
    input  logic                       bubble_en,
    input  logic [5:0]                 bubble_pos,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [62:0]                out_raw,
    output logic [2:0]                 out_cnt_a,
    output logic [2:0]                 out_cnt_b,
    output logic                       out_code_err
);

`ifdef TOA_RAW_GEN_SWEEP_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_SWEEP = 2'd2, ST_DONE = 2'd3} state_t;
    localparam logic [SWEEP_LEN_WIDTH-1:0] REM_ONE = {{(SWEEP_LEN_WIDTH-1){1'b0}}, 1'b1};
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1} state_t;
`endif

    // Equal-bit pair sits at (p-1, p); the upper half of the fine range is the inverted word.
    function automatic logic [62:0] encode_raw(input logic [6:0] fine);
        logic       h;
        logic [6:0] p;
        logic [62:0] base;
        h    = (fine >= 7'd63);
        p    = h ? (fine - 7'd63) : fine;
        base = {63{1'b0}};
        for (int i = 0; i < 63; i++) begin
            if (7'(i) < p) begin
                base[i] = ~i[0];
            end else begin
                base[i] = i[0];
            end
        end
        return base ^ {63{h}};
    endfunction

    // Packed beat: {code_err, cnt_b, cnt_a, raw}, bubble applied after encoding.
    function automatic logic [69:0] encode_beat(input logic [2:0] c, input logic [6:0] f,
                                                input logic ben, input logic [5:0] bpos);
        logic [62:0] raw;
        logic [2:0]  cb;
        logic        err;
        if (f > 7'd125) begin
            raw = {63{1'b0}};
            cb  = c;
            err = 1'b1;
        end else begin
            raw = encode_raw(f);
            cb  = (f >= 7'd63) ? (c - 3'd1) : c;
            err = 1'b0;
        end
        if (ben && (bpos < 6'd63)) begin
            raw[bpos] = ~raw[bpos];
        end else begin
            raw = raw;
        end
        return {err, cb, c, raw};
    endfunction

`ifdef TOA_RAW_GEN_SWEEP_EN
    // Next sweep code: {coarse, fine}; fine wraps at 126 and carries into coarse.
    function automatic logic [9:0] sweep_next(input logic [2:0] c, input logic [6:0] f,
                                              input logic [6:0] step);
        logic [7:0] s;
        logic [2:0] nc;
        logic [6:0] nf;
        s = {1'b0, f} + {1'b0, step};
        if (s >= 8'd126) begin
            nf = 7'(s - 8'd126);
            nc = c + 3'd1;
        end else begin
            nf = s[6:0];
            nc = c;
        end
        return {nc, nf};
    endfunction
`endif

    state_t      state_r, state_nxt;
    logic        out_valid_r, out_valid_nxt;
    logic [62:0] out_raw_r;
    logic [2:0]  out_cnt_a_r, out_cnt_b_r;
    logic        out_code_err_r;
    logic        load_s, accept_out_s, in_ready_s;
    logic [2:0]  ld_coarse_s;
    logic [6:0]  ld_fine_s;
    logic [69:0] beat_s;

`ifdef TOA_RAW_GEN_SWEEP_EN
    logic                       sweep_busy_r, sweep_busy_nxt;
    logic                       sweep_done_r, sweep_done_nxt;
    logic                       zero_len_s;
    logic [2:0]                 sw_coarse_r, sw_coarse_nxt;
    logic [6:0]                 sw_fine_r, sw_fine_nxt;
    logic [6:0]                 sw_step_r, sw_step_nxt;
    logic [SWEEP_LEN_WIDTH-1:0] sw_rem_r, sw_rem_nxt;
    assign sweep_busy = sweep_busy_r;
    assign sweep_done = sweep_done_r;
`else
    logic unused_sweep_s;
    assign unused_sweep_s = ^{sweep_start, sweep_step, sweep_len};
    assign sweep_busy     = 1'b0;
    assign sweep_done     = 1'b0;
`endif

    assign accept_out_s = out_valid_r & out_ready;
    assign in_ready_s   = !rst & !sweep_busy & (!out_valid_r | out_ready);
    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign out_raw      = out_raw_r;
    assign out_cnt_a    = out_cnt_a_r;
    assign out_cnt_b    = out_cnt_b_r;
    assign out_code_err = out_code_err_r;

    // Next-state, next-beat and sweep bookkeeping.
    always_comb begin
        state_nxt     = state_r;
        out_valid_nxt = out_valid_r;
        load_s        = 1'b0;
        ld_coarse_s   = in_coarse;
        ld_fine_s     = in_fine;
`ifdef TOA_RAW_GEN_SWEEP_EN
        zero_len_s    = 1'b0;
        sw_coarse_nxt = sw_coarse_r;
        sw_fine_nxt   = sw_fine_r;
        sw_step_nxt   = sw_step_r;
        sw_rem_nxt    = sw_rem_r;
`endif
        case (state_r)
            ST_IDLE: begin
`ifdef TOA_RAW_GEN_SWEEP_EN
                if (sweep_start) begin
                    if (sweep_len != {SWEEP_LEN_WIDTH{1'b0}}) begin
                        state_nxt     = ST_SWEEP;
                        load_s        = 1'b1;
                        sw_coarse_nxt = in_coarse;
                        sw_fine_nxt   = in_fine;
                        sw_step_nxt   = sweep_step;
                        sw_rem_nxt    = sweep_len;
                    end else begin
                        zero_len_s = 1'b1;
                    end
                end else
`endif
                if (in_valid && in_ready_s) begin
                    state_nxt = ST_LOAD;
                    load_s    = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_out_s) begin
                    if (in_valid) begin
                        load_s = 1'b1;
                    end else begin
                        state_nxt     = ST_IDLE;
                        out_valid_nxt = 1'b0;
                    end
                end else begin
                    state_nxt = ST_LOAD;
                end
            end
`ifdef TOA_RAW_GEN_SWEEP_EN
            ST_SWEEP: begin
                if (accept_out_s) begin
                    if (sw_rem_r == REM_ONE) begin
                        state_nxt     = ST_DONE;
                        out_valid_nxt = 1'b0;
                    end else begin
                        {sw_coarse_nxt, sw_fine_nxt} = sweep_next(sw_coarse_r, sw_fine_r, sw_step_r);
                        sw_rem_nxt  = sw_rem_r - REM_ONE;
                        load_s      = 1'b1;
                        ld_coarse_s = sw_coarse_nxt;
                        ld_fine_s   = sw_fine_nxt;
                    end
                end else begin
                    state_nxt = ST_SWEEP;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
`endif
            default: begin
                state_nxt     = ST_IDLE;
                out_valid_nxt = 1'b0;
            end
        endcase

        if (load_s) begin
            out_valid_nxt = 1'b1;
            beat_s        = encode_beat(ld_coarse_s, ld_fine_s, bubble_en, bubble_pos);
        end else begin
            beat_s = {out_code_err_r, out_cnt_b_r, out_cnt_a_r, out_raw_r};
        end
`ifdef TOA_RAW_GEN_SWEEP_EN
        sweep_busy_nxt = (state_nxt == ST_SWEEP) || (state_nxt == ST_DONE);
        sweep_done_nxt = zero_len_s || (state_nxt == ST_DONE);
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Output beat and sweep registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r    <= 1'b0;
            out_raw_r      <= {63{1'b0}};
            out_cnt_a_r    <= 3'd0;
            out_cnt_b_r    <= 3'd0;
            out_code_err_r <= 1'b0;
`ifdef TOA_RAW_GEN_SWEEP_EN
            sweep_busy_r   <= 1'b0;
            sweep_done_r   <= 1'b0;
            sw_coarse_r    <= 3'd0;
            sw_fine_r      <= 7'd0;
            sw_step_r      <= 7'd0;
            sw_rem_r       <= {SWEEP_LEN_WIDTH{1'b0}};
`endif
        end else begin
            out_valid_r    <= out_valid_nxt;
            out_raw_r      <= beat_s[62:0];
            out_cnt_a_r    <= beat_s[65:63];
            out_cnt_b_r    <= beat_s[68:66];
            out_code_err_r <= beat_s[69];
`ifdef TOA_RAW_GEN_SWEEP_EN
            sweep_busy_r   <= sweep_busy_nxt;
            sweep_done_r   <= sweep_done_nxt;
            sw_coarse_r    <= sw_coarse_nxt;
            sw_fine_r      <= sw_fine_nxt;
            sw_step_r      <= sw_step_nxt;
            sw_rem_r       <= sw_rem_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_toa_raw_generator.sv
// Scoreboard bench for toa_raw_generator: expected beats queued at stimulus time, compared as they are accepted.
module tb_toa_raw_generator;
    localparam int LW = 12;
    localparam logic [62:0] ALT = 63'h2AAA_AAAA_AAAA_AAAA;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_coarse = 3'd0;
    logic [6:0]    in_fine = 7'd0;
    logic          sweep_start = 1'b0;
    logic [6:0]    sweep_step = 7'd1;
    logic [LW-1:0] sweep_len = 12'd0;
    logic          sweep_busy, sweep_done;
    logic          bubble_en = 1'b0;
    logic [5:0]    bubble_pos = 6'd0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [62:0]   out_raw;
    logic [2:0]    out_cnt_a, out_cnt_b;
    logic          out_code_err;

    toa_raw_generator #(.SWEEP_LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_coarse(in_coarse), .in_fine(in_fine), .sweep_start(sweep_start),
        .sweep_step(sweep_step), .sweep_len(sweep_len), .sweep_busy(sweep_busy),
        .sweep_done(sweep_done), .bubble_en(bubble_en), .bubble_pos(bubble_pos),
        .out_valid(out_valid), .out_ready(out_ready), .out_raw(out_raw),
        .out_cnt_a(out_cnt_a), .out_cnt_b(out_cnt_b), .out_code_err(out_code_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [69:0] sb[$];
    logic [69:0] dut_beat;
    logic [69:0] held_beat = 70'd0;
    logic        stalled = 1'b0;

    assign dut_beat = {out_code_err, out_cnt_b, out_cnt_a, out_raw};

    task automatic check_val(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: alternating word with the low p bits flipped, inverted for the upper half.
    function automatic logic [69:0] model_beat(input logic [2:0] c, input logic [6:0] f,
                                               input logic ben, input logic [5:0] bpos);
        logic [62:0] raw;
        logic [2:0]  cb;
        logic        err;
        int          p;
        if (f >= 7'd126) begin
            raw = 63'd0;
            cb  = c;
            err = 1'b1;
        end else begin
            p   = (f >= 7'd63) ? int'(f) - 63 : int'(f);
            raw = ALT ^ ((63'd1 << p) - 63'd1);
            cb  = c;
            if (f >= 7'd63) begin
                raw = ~raw;
                cb  = c - 3'd1;
            end
            err = 1'b0;
        end
        if (ben && bpos < 6'd63) raw[bpos] = ~raw[bpos];
        return {err, cb, c, raw};
    endfunction

    // Beat monitor: hold stability under backpressure and in-order scoreboard compare on accept.
    always @(negedge clk) begin
        if (rst) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) begin
                check_val("hold_beat", dut_beat, held_beat);
                check_val("hold_valid", 70'(out_valid), 70'd1);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check_val("spurious_beat", 70'(sb.size()), 70'd1);
                else check_val("beat", dut_beat, sb.pop_front());
            end
            stalled   <= out_valid && !out_ready;
            held_beat <= dut_beat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c, input logic [6:0] f, input logic ben, input logic [5:0] bpos);
        in_coarse = c; in_fine = f; bubble_en = ben; bubble_pos = bpos; in_valid = 1'b1;
        #1;
        check_val("send_ready", 70'(in_ready), 70'd1);
        sb.push_back(model_beat(c, f, ben, bpos));
        tick();
        in_valid = 1'b0; bubble_en = 1'b0;
        check_val("latency_valid", 70'(out_valid), 70'd1);
    endtask

    task automatic drain();
        int w = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && w < 50) begin
            tick();
            w++;
        end
        check_val("drain", 70'(sb.size()), 70'd0);
    endtask

`ifdef TOA_RAW_GEN_SWEEP_EN
    task automatic start_sweep(input logic [2:0] c, input logic [6:0] f, input logic [6:0] step,
                               input int len, input logic iv);
        int t;
        in_coarse = c; in_fine = f; sweep_step = step; sweep_len = LW'(len);
        sweep_start = 1'b1; in_valid = iv;
        t = int'(c) * 126 + int'(f);
        for (int k = 0; k < len; k++) begin
            sb.push_back(model_beat(3'(t / 126), 7'(t % 126), bubble_en, bubble_pos));
            t = (t + int'(step)) % 1008;
        end
        tick();
        sweep_start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int   w = 0;
        logic seen = 1'b0;
        while (!seen && w < 40) begin
            if (sweep_done) seen = 1'b1;
            else begin
                tick();
                w++;
            end
        end
        check_val("done_seen", 70'(seen), 70'd1);
        tick();
        check_val("busy_after_done", 70'(sweep_busy), 70'd0);
    endtask
`endif

    initial begin
        @(negedge clk);
        check_val("rst_in_ready", 70'(in_ready), 70'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_beat", dut_beat, 70'd0);
        check_val("rst_flags", 70'({out_valid, sweep_busy, sweep_done}), 70'd0);
        rst = 1'b0;
        #1;
        check_val("post_rst_ready", 70'(in_ready), 70'd1);

        // Directed single codes
        send(3'd0, 7'd0, 1'b0, 6'd0);
        check_val("c0f0", dut_beat, {1'b0, 3'd0, 3'd0, ALT});
        tick();
        check_val("load_release", 70'(out_valid), 70'd0);
        send(3'd2, 7'd10, 1'b0, 6'd0);
        check_val("c2f10_low", 70'(out_raw[11:0]), 70'h955);
        check_val("c2f10_cnt", 70'({out_cnt_a, out_cnt_b}), 70'({3'd2, 3'd2}));
        drain();
        send(3'd0, 7'd63, 1'b0, 6'd0);
        check_val("c0f63", dut_beat, {1'b0, 3'd7, 3'd0, 63'h5555_5555_5555_5555});
        drain();
        send(3'd4, 7'd126, 1'b0, 6'd0);
        check_val("illegal", dut_beat, {1'b1, 3'd4, 3'd4, 63'd0});
        drain();
        send(3'd0, 7'd0, 1'b1, 6'd0);
        check_val("bubble0", 70'(out_raw), 70'(63'h2AAA_AAAA_AAAA_AAAB));
        drain();
        send(3'd1, 7'd5, 1'b1, 6'd63);
        send(3'd5, 7'd125, 1'b1, 6'd62);
        drain();

        // Backpressure on a single code
        out_ready = 1'b0;
        send(3'd6, 7'd100, 1'b1, 6'd30);
        repeat (5) begin
            tick();
            check_val("bp_in_ready", 70'(in_ready), 70'd0);
        end
        out_ready = 1'b1;
        tick();
        check_val("bp_release", 70'(out_valid), 70'd0);

        // Random single-code traffic with random backpressure
        for (int k = 0; k < 60; k++) begin
            in_coarse  = 3'($urandom_range(0, 7));
            in_fine    = 7'($urandom_range(0, 127));
            bubble_en  = 1'($urandom_range(0, 1));
            bubble_pos = 6'($urandom_range(0, 63));
            in_valid   = ($urandom_range(0, 2) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            #1;
            check_val("in_ready_rule", 70'(in_ready), 70'(!out_valid || out_ready));
            if (in_valid && in_ready) sb.push_back(model_beat(in_coarse, in_fine, bubble_en, bubble_pos));
            tick();
        end
        in_valid = 1'b0; bubble_en = 1'b0;
        drain();

`ifdef TOA_RAW_GEN_SWEEP_EN
        // Gapless sweep across the coarse wrap
        start_sweep(3'd7, 7'd124, 7'd1, 3, 1'b0);
        for (int b = 0; b < 3; b++) begin
            check_val("sweep_gapless", 70'({out_valid, sweep_busy, sweep_done}), 70'(3'b110));
            tick();
        end
        check_val("sweep_done_pulse", 70'({out_valid, sweep_busy, sweep_done}), 70'(3'b011));
        tick();
        check_val("sweep_idle", 70'({out_valid, sweep_busy, sweep_done}), 70'd0);
        drain();

        // Sweep with bubble, stalls and an ignored restart
        bubble_en = 1'b1; bubble_pos = 6'd5;
        start_sweep(3'd3, 7'd100, 7'd37, 6, 1'b0);
        tick();
        out_ready = 1'b0; sweep_start = 1'b1; sweep_len = 12'd2; in_fine = 7'd1;
        for (int s = 0; s < 5; s++) begin
            tick();
            sweep_start = 1'b0;
            check_val("stall_busy", 70'(sweep_busy), 70'd1);
        end
        out_ready = 1'b1;
        wait_done();
        bubble_en = 1'b0;
        drain();

        // Zero-length sweep
        start_sweep(3'd1, 7'd1, 7'd1, 0, 1'b0);
        check_val("zero_len", 70'({out_valid, sweep_busy, sweep_done}), 70'(3'b001));
        tick();
        check_val("zero_len_after", 70'(sweep_done), 70'd0);

        // Sweep beats a simultaneous single-code request
        start_sweep(3'd2, 7'd20, 7'd3, 1, 1'b1);
        wait_done();
        drain();

        // Reset mid-sweep
        start_sweep(3'd0, 7'd0, 7'd50, 10, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_val("rst_mid_beat", dut_beat, 70'd0);
        check_val("rst_mid_flags", 70'({out_valid, sweep_busy, sweep_done}), 70'd0);
        sb.delete();
        rst = 1'b0;
        for (int s = 0; s < 5; s++) begin
            check_val("rst_no_done", 70'({out_valid, sweep_done}), 70'd0);
            tick();
        end
`else
        // Sweep controls have no effect in the single-code build
        sweep_len = 12'd3; sweep_step = 7'd1; sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int s = 0; s < 4; s++) begin
            check_val("no_sweep", 70'({out_valid, sweep_busy, sweep_done}), 70'd0);
            tick();
        end
`endif

        check_val("sb_empty", 70'(sb.size()), 70'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
